wb_stage: RTL and testbench

Writeback stage of the pipelined core: accepts retiring instructions from the memory stage over a valid/ready handshake, waits for load data from the data-memory response port, extracts and sign/zero-extends load results, then drives one registered write per instruction into the register file. It also publishes the committing PC for difftest and the in-flight destination for forwarding and hazard logic.

---
 rtl/npc_pkg.sv | 44 ++++
 rtl/wb_stage_load_extend.sv | 45 ++++
 rtl/wb_stage.sv | 131 +++++++++++++
 tb/tb_wb_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types and widths for the core pipeline stages.
// Load sizes match the memory-stage encoding; writeback FSM states live here too.
package npc_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10,
        LD_D = 2'b11
    } ld_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_LD = 2'b01,
        COMMIT  = 2'b10
    } wb_state_e;

    // Context of a load parked while the data-memory response is outstanding.
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_wen;
        ld_size_e              size;
        logic                  is_unsigned;
        logic [2:0]            offset;
    } ld_ctx_t;

    localparam ld_ctx_t LD_CTX_RESET = '{
        pc:          '0,
        rd:          '0,
        rd_wen:      1'b0,
        size:        LD_B,
        is_unsigned: 1'b0,
        offset:      3'b000
    };

    function automatic logic rf_write(input logic rd_wen, input logic [REG_ADDR_W-1:0] rd);
        return rd_wen && (rd != '0);
    endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load data alignment: picks the addressed lane out of an aligned doubleword and
// sign/zero-extends it to XLEN; purely combinational, no handshake.
module load_extend
    import npc_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      offset_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);

    ld_size_e        size;
    logic [2:0]      lane_off;
    logic [XLEN-1:0] shifted;

    assign size = ld_size_e'(size_i);

    // Offset bits below the access size are dropped, so misaligned addresses alias down.
    always_comb begin
        lane_off = 3'b000;
        case (size)
            LD_B:    lane_off = offset_i;
            LD_H:    lane_off = {offset_i[2:1], 1'b0};
            LD_W:    lane_off = {offset_i[2], 2'b00};
            default: lane_off = 3'b000;
        endcase
    end

    assign shifted = rdata_i >> {lane_off, 3'b000};

    always_comb begin
        data_o = shifted;
        case (size)
            LD_B: data_o = unsigned_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                      : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            LD_H: data_o = unsigned_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                      : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LD_W: data_o = unsigned_i ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                      : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one registered register-file write per retiring instruction, 1 cycle after
// accept for ALU ops, 1 cycle after load response for loads; stalls upstream only while a load waits.
module wb_stage
    import npc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [XLEN-1:0]       mem_pc_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_rd_wen_i,
    input  logic [XLEN-1:0]       mem_res_i,
    input  logic                  mem_is_load_i,
    input  logic [1:0]            mem_ld_size_i,
    input  logic                  mem_ld_unsigned_i,

    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,

    output logic                  wr_en_o,
    output logic [REG_ADDR_W-1:0] wr_addr_o,
    output logic [XLEN-1:0]       wr_data_o,

    output logic                  commit_o,
    output logic [XLEN-1:0]       pc_wb_o,

    output logic                  ld_pending_o,
    output logic [REG_ADDR_W-1:0] ld_pending_rd_o
);

    wb_state_e             state_q, state_d;
    ld_ctx_t               ld_q, ld_d;

    logic                  commit_q, commit_d;
    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]       wr_data_q, wr_data_d;
    logic [XLEN-1:0]       pc_wb_q, pc_wb_d;

    logic                  accept;
    logic [XLEN-1:0]       ld_data;

    load_extend u_load_extend (
        .rdata_i    (dmem_rdata_i),
        .offset_i   (ld_q.offset),
        .size_i     (ld_q.size),
        .unsigned_i (ld_q.is_unsigned),
        .data_o     (ld_data)
    );

    assign mem_ready_o = (state_q != WAIT_LD);
    assign accept      = mem_valid_i && mem_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ld_q      <= LD_CTX_RESET;
            commit_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pc_wb_q   <= '0;
        end else begin
            state_q   <= state_d;
            ld_q      <= ld_d;
            commit_q  <= commit_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pc_wb_q   <= pc_wb_d;
        end
    end

    // Commit outputs default to zero so every non-commit cycle presents an all-zero bus.
    always_comb begin
        state_d   = state_q;
        ld_d      = ld_q;
        commit_d  = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        pc_wb_d   = '0;

        case (state_q)
            WAIT_LD: begin
                if (dmem_rvalid_i) begin
                    commit_d  = 1'b1;
                    wr_en_d   = rf_write(ld_q.rd_wen, ld_q.rd);
                    wr_addr_d = ld_q.rd;
                    wr_data_d = ld_data;
                    pc_wb_d   = ld_q.pc;
                    state_d   = COMMIT;
                end
            end
            default: begin
                if (accept) begin
                    if (mem_is_load_i) begin
                        ld_d.pc          = mem_pc_i;
                        ld_d.rd          = mem_rd_i;
                        ld_d.rd_wen      = mem_rd_wen_i;
                        ld_d.size        = ld_size_e'(mem_ld_size_i);
                        ld_d.is_unsigned = mem_ld_unsigned_i;
                        ld_d.offset      = mem_res_i[2:0];
                        state_d          = WAIT_LD;
                    end else begin
                        commit_d  = 1'b1;
                        wr_en_d   = rf_write(mem_rd_wen_i, mem_rd_i);
                        wr_addr_d = mem_rd_i;
                        wr_data_d = mem_res_i;
                        pc_wb_d   = mem_pc_i;
                        state_d   = COMMIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign commit_o  = commit_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign pc_wb_o   = pc_wb_q;

    assign ld_pending_o    = (state_q == WAIT_LD);
    assign ld_pending_rd_o = (ld_pending_o && ld_q.rd_wen) ? ld_q.rd : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: drive #1 after posedge, check #1 after posedge.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [63:0] mem_pc_i;
    logic [4:0]  mem_rd_i;
    logic        mem_rd_wen_i;
    logic [63:0] mem_res_i;
    logic        mem_is_load_i;
    logic [1:0]  mem_ld_size_i;
    logic        mem_ld_unsigned_i;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic        wr_en_o;
    logic [4:0]  wr_addr_o;
    logic [63:0] wr_data_o;
    logic        commit_o;
    logic [63:0] pc_wb_o;
    logic        ld_pending_o;
    logic [4:0]  ld_pending_rd_o;

    int total = 0;
    int bad   = 0;

    wb_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_valid_i       (mem_valid_i),
        .mem_ready_o       (mem_ready_o),
        .mem_pc_i          (mem_pc_i),
        .mem_rd_i          (mem_rd_i),
        .mem_rd_wen_i      (mem_rd_wen_i),
        .mem_res_i         (mem_res_i),
        .mem_is_load_i     (mem_is_load_i),
        .mem_ld_size_i     (mem_ld_size_i),
        .mem_ld_unsigned_i (mem_ld_unsigned_i),
        .dmem_rvalid_i     (dmem_rvalid_i),
        .dmem_rdata_i      (dmem_rdata_i),
        .wr_en_o           (wr_en_o),
        .wr_addr_o         (wr_addr_o),
        .wr_data_o         (wr_data_o),
        .commit_o          (commit_o),
        .pc_wb_o           (pc_wb_o),
        .ld_pending_o      (ld_pending_o),
        .ld_pending_rd_o   (ld_pending_rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                             input logic [63:0] res);
        mem_valid_i   = 1'b1;
        mem_pc_i      = pc;
        mem_rd_i      = rd;
        mem_rd_wen_i  = wen;
        mem_res_i     = res;
        mem_is_load_i = 1'b0;
    endtask

    task automatic drive_load(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] addr,
                              input logic [1:0] size, input logic uns);
        mem_valid_i       = 1'b1;
        mem_pc_i          = pc;
        mem_rd_i          = rd;
        mem_rd_wen_i      = 1'b1;
        mem_res_i         = addr;
        mem_is_load_i     = 1'b1;
        mem_ld_size_i     = size;
        mem_ld_unsigned_i = uns;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".commit"}, {63'd0, commit_o}, 64'd0);
        chk({tag, ".wr_en"},  {63'd0, wr_en_o}, 64'd0);
        chk({tag, ".addr"},   {59'd0, wr_addr_o}, 64'd0);
        chk({tag, ".data"},   wr_data_o, 64'd0);
        chk({tag, ".pc"},     pc_wb_o, 64'd0);
        chk({tag, ".ready"},  {63'd0, mem_ready_o}, 64'd1);
        chk({tag, ".pend"},   {63'd0, ld_pending_o}, 64'd0);
        chk({tag, ".pendrd"}, {59'd0, ld_pending_rd_o}, 64'd0);
    endtask

    task automatic chk_commit(input string tag, input logic wen, input logic [4:0] rd,
                              input logic [63:0] data, input logic [63:0] pc);
        chk({tag, ".commit"}, {63'd0, commit_o}, 64'd1);
        chk({tag, ".wr_en"},  {63'd0, wr_en_o}, {63'd0, wen});
        chk({tag, ".pc"},     pc_wb_o, pc);
        if (wen) begin
            chk({tag, ".addr"}, {59'd0, wr_addr_o}, {59'd0, rd});
            chk({tag, ".data"}, wr_data_o, data);
        end
    endtask

    // One full load: accept, one wait cycle with rvalid, then the commit cycle.
    task automatic run_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
        drive_load(64'h8000_1000, 5'd7, addr, size, uns);
        step();
        mem_valid_i = 1'b0;
        chk({tag, ".pend"}, {63'd0, ld_pending_o}, 64'd1);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        step();
        dmem_rvalid_i = 1'b0;
        chk_commit(tag, 1'b1, 5'd7, exp, 64'h8000_1000);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_valid_i = 1'b0; mem_pc_i = '0; mem_rd_i = '0; mem_rd_wen_i = 1'b0;
        mem_res_i = '0; mem_is_load_i = 1'b0; mem_ld_size_i = 2'b00; mem_ld_unsigned_i = 1'b0;
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        step();
        step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();

        // Single ALU op
        drive_alu(64'h8000_0000, 5'd5, 1'b1, 64'h1234);
        step();
        mem_valid_i = 1'b0;
        chk_commit("alu", 1'b1, 5'd5, 64'h1234, 64'h8000_0000);
        step();
        chk_idle("alu_after");

        // Back-to-back ALU ops, full throughput
        for (int i = 1; i <= 3; i++) begin
            drive_alu(64'h100 + 64'(4 * i), 5'(i), 1'b1, 64'(i * 17));
            chk("b2b.ready", {63'd0, mem_ready_o}, 64'd1);
            step();
            chk_commit("b2b", 1'b1, 5'(i), 64'(i * 17), 64'h100 + 64'(4 * i));
        end
        mem_valid_i = 1'b0;
        step();
        chk("b2b_end.commit", {63'd0, commit_o}, 64'd0);

        // Load extraction
        run_load("lb",  64'h1003, 2'b00, 1'b0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lbu", 64'h1003, 2'b00, 1'b1, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080);
        run_load("lw",  64'h2004, 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
        run_load("lh_mis", 64'h1003, 2'b01, 1'b0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_80FF);
        run_load("lhu", 64'h100E, 2'b01, 1'b1, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF);
        run_load("lwu", 64'h2004, 2'b10, 1'b1, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);

        // Delayed response with a held upstream instruction
        drive_load(64'h3000, 5'd9, 64'h3005, 2'b11, 1'b0);
        step();
        drive_alu(64'h3004, 5'd10, 1'b1, 64'hABCD);
        for (int i = 0; i < 3; i++) begin
            chk("wait.ready",  {63'd0, mem_ready_o}, 64'd0);
            chk("wait.pend",   {63'd0, ld_pending_o}, 64'd1);
            chk("wait.pendrd", {59'd0, ld_pending_rd_o}, 64'd9);
            chk("wait.commit", {63'd0, commit_o}, 64'd0);
            step();
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'hDEAD_BEEF_CAFE_F00D;
        chk("wait.ready_rv", {63'd0, mem_ready_o}, 64'd0);
        step();
        dmem_rvalid_i = 1'b0;
        chk_commit("ld_d", 1'b1, 5'd9, 64'hDEAD_BEEF_CAFE_F00D, 64'h3000);
        chk("ld_d.ready", {63'd0, mem_ready_o}, 64'd1);
        step();
        mem_valid_i = 1'b0;
        chk_commit("held_alu", 1'b1, 5'd10, 64'hABCD, 64'h3004);
        step();
        chk_idle("pre_stray");

        // Stray rvalid while idle
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'h1111_2222_3333_4444;
        step();
        dmem_rvalid_i = 1'b0;
        chk_idle("stray");

        // rd = 0 still commits without writing
        drive_alu(64'h200, 5'd0, 1'b1, 64'h55);
        step();
        mem_valid_i = 1'b0;
        chk_commit("rd0", 1'b0, 5'd0, 64'h0, 64'h200);
        step();

        // Reset while a load waits
        drive_load(64'h400, 5'd4, 64'h4000, 2'b11, 1'b0);
        step();
        mem_valid_i = 1'b0;
        chk("rstld.pend", {63'd0, ld_pending_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("rstld.in_reset");
        #1;
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 64'h5555_6666_7777_8888;
        step();
        dmem_rvalid_i = 1'b0;
        chk_idle("rstld.late_rv");
        step();
        chk_idle("rstld.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
